spi_ram: RTL
============

Name: spi_ram

Overview:
- Single-port synchronous RAM sitting directly downstream of the SPI slave controller.
- Consumes the 10-bit frames (rx_data/rx_valid) the slave assembles from MOSI.
- The two MSBs of each frame are a command that either latches an address, writes a byte, or reads a byte.
- Read results return to the slave on tx_data/tx_valid for serialisation onto MISO.

Parameters:
- MEM_DEPTH, 256, number of byte locations.
- ADDR_SIZE, 8, address width; MEM_DEPTH must equal 2**ADDR_SIZE.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-low (rst=0 resets).
- rx_data  input  10  frame from SPI slave; [9:8]=command, [7:0]=address or data.
- rx_valid  input  1  one-cycle qualifier for rx_data.
- tx_data  output  8  read data returned to SPI slave.
- tx_valid  output  1  one-cycle pulse, tx_data valid.
- seq_err  output  1  one-cycle pulse, out-of-order command rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_data=0, tx_valid=0, seq_err=0.
  - wr_addr=0, rd_addr=0, wr_addr_ok=0, rd_addr_ok=0.
  - Memory contents are not reset.
- Commands are decoded only in cycles with rx_valid=1; all outputs are registered.
- 2'b00 WR_ADDR: wr_addr<=rx_data[7:0]; wr_addr_ok<=1.
- 2'b01 WR_DATA:
  - if wr_addr_ok: mem[wr_addr]<=rx_data[7:0].
  - else: no write; seq_err pulses next cycle.
- 2'b10 RD_ADDR: rd_addr<=rx_data[7:0]; rd_addr_ok<=1.
- 2'b11 RD_DATA:
  - if rd_addr_ok: tx_data<=mem[rd_addr]; tx_valid=1 for exactly one cycle, one cycle after the rx_valid cycle (latency 1).
  - else: tx_data unchanged, tx_valid stays 0, seq_err pulses.
  - rx_data[7:0] is a don't-care.
- Between reads, tx_data holds its last value.
- tx_valid and seq_err are never high in the same cycle.
- Address flags persist across frames. They are cleared only by reset, so repeated WR_DATA or RD_DATA frames reuse the latched address.
- Read after write to the same location in consecutive frames returns the new value; there is no bypass needed because the commands are in separate cycles.
- Back-to-back rx_valid on consecutive cycles must be accepted. Each frame is processed independently, one command per cycle.
- Reset asserted mid-read (between the rx_valid cycle and the tx_valid cycle) suppresses the tx_valid pulse.
- Address values wrap naturally within ADDR_SIZE; there is no out-of-range case.

Optional Feature:
- Macro: SPI_RAM_AUTOINC_EN.
- Defined:
  - each accepted WR_DATA post-increments wr_addr by 1, modulo MEM_DEPTH (0xFF -> 0x00);
  - each accepted RD_DATA post-increments rd_addr the same way;
  - this enables burst transfers without re-sending the address.
- Undefined: addresses change only on WR_ADDR/RD_ADDR.
- Error, reject and reset behaviour is identical in both builds. A rejected command never increments.

Decomposition:
- Shared package spi_pkg holds:
  - command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_W=10 and DATA_W=8;
  - default ADDR_SIZE/MEM_DEPTH.
- The SPI slave controller imports the same package.
- One natural sub-module, spi_ram_array: pure storage with a write port (we, waddr, wdata) and a registered read port (re, raddr, rdata).
- spi_ram keeps the command decoder, address registers, flags and handshake outputs.

Test Plan:
- Reset, then frame 11_00000000 -> no tx_valid, seq_err pulses 1 cycle later, tx_data stays 0x00.
- 00_0x3C, 01_0xA5, 10_0x3C, 11_xx -> tx_valid pulse exactly 1 cycle after the RD_DATA rx_valid, tx_data=0xA5.
- Frame 01_0x55 directly after reset -> seq_err pulse. Then 10_0x00, 11_xx -> memory unmodified: location 0x00 holds its prior (preloaded) value.
- Back-to-back rx_valid: 00_0x10, 01_0x77, 10_0x10, 11_xx on 4 consecutive cycles -> tx_data=0x77, single tx_valid pulse.
- Assert rst low in the cycle after a RD_DATA rx_valid -> tx_valid never asserts, all outputs 0.
- With SPI_RAM_AUTOINC_EN:
  - 00_0xFF, then 01 frames 0x11 and 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22;
  - 10_0xFF, then two 11 frames -> tx_data 0x11 then 0x22.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame layout, command encodings, default RAM geometry.
package spi_pkg;

    localparam int FRAME_W   = 10;
    localparam int DATA_W    = 8;
    localparam int ADDR_SIZE = 8;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/spi_ram_array.sv
// Byte storage behind spi_ram: one write port and one registered read port.
// Memory contents are never reset; only the read register is.
module spi_ram_array
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = spi_pkg::ADDR_SIZE,
    parameter int MEM_DEPTH = spi_pkg::MEM_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds between reads; it doubles as the slave's tx_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// Command decoder for the SPI slave RAM: address latches, flags, handshakes.
// Define SPI_RAM_AUTOINC_EN to post-increment addresses on accepted data frames.
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = spi_pkg::MEM_DEPTH,
    parameter int ADDR_SIZE = spi_pkg::ADDR_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] rx_data,
    input  logic               rx_valid,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_valid,
    output logic               seq_err
);

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_ok;
    logic                 rd_addr_ok;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 bad_cmd;

    assign cmd     = cmd_e'(rx_data[FRAME_W-1:FRAME_W-2]);
    assign payload = rx_data[ADDR_SIZE-1:0];
    assign wr_fire = rx_valid && (cmd == CMD_WR_DATA) && wr_addr_ok;
    assign rd_fire = rx_valid && (cmd == CMD_RD_DATA) && rd_addr_ok;
    assign bad_cmd = rx_valid
                  && (((cmd == CMD_WR_DATA) && !wr_addr_ok)
                   || ((cmd == CMD_RD_DATA) && !rd_addr_ok));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_addr_ok <= 1'b0;
            rd_addr_ok <= 1'b0;
            tx_valid   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            tx_valid <= rd_fire;
            seq_err  <= bad_cmd;
            if (rx_valid) begin
                unique case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr    <= payload;
                        wr_addr_ok <= 1'b1;
                    end
                    CMD_RD_ADDR: begin
                        rd_addr    <= payload;
                        rd_addr_ok <= 1'b1;
                    end
`ifdef SPI_RAM_AUTOINC_EN
                    CMD_WR_DATA: begin
                        if (wr_addr_ok) begin
                            wr_addr <= wr_addr + ADDR_SIZE'(1);
                        end
                    end
                    CMD_RD_DATA: begin
                        if (rd_addr_ok) begin
                            rd_addr <= rd_addr + ADDR_SIZE'(1);
                        end
                    end
`else
                    CMD_WR_DATA: begin
                    end
                    CMD_RD_DATA: begin
                    end
`endif
                endcase
            end
        end
    end

    spi_ram_array #(
        .ADDR_SIZE (ADDR_SIZE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr (wr_addr),
        .wdata (rx_data[DATA_W-1:0]),
        .re    (rd_fire),
        .raddr (rd_addr),
        .rdata (tx_data)
    );

endmodule
